pipe_inst_issuer: RTL and testbench
===================================

// Module: pipe_inst_issuer
// PURPOSE
//  Instruction-side driver for the 4-register ADD/SET/NAND pipeline: the transmitter end of its
//  inst/inst_valid/inst_ready handshake. Host preloads a short program (8-bit insts) into a buffer.
//  On start, the block replays it once or in a loop, honouring backpressure. It also drives
//  pseudo-random stallex/stallwb so scoreboard/interlock paths are exercised.
// PARAMETERS
//  DEPTH      8      program buffer entries; power of 2, >=2
//  CNTW       16     width of issued_cnt
//  LFSR_SEED  8'hA5  stall LFSR reset value; must be nonzero
// PORTS
//  clk          in   1     clock
//  rst          in   1     synchronous, active-high reset
//  ld_inst      in   8     program word: op[7:6] rs1[5:4] rs2[3:2] rd[1:0]; SET imm=[5:2]
//  ld_valid     in   1     load request
//  ld_ready     out  1     buffer accepts load
//  ld_clear     in   1     empty program buffer (IDLE only)
//  start        in   1     begin issuing (IDLE only)
//  loop_en      in   1     wrap to entry 0 after last entry; sampled every handshake
//  abort        in   1     stop after the current offered instruction
//  stall_en     in   1     enable pseudo-random stall generation
//  inst         out  8     instruction to pipeline
//  inst_valid   out  1     inst is valid
//  inst_ready   in   1     pipeline accepts inst
//  stallex      out  1     EX-stage stall to pipeline
//  stallwb      out  1     WB-stage stall to pipeline
//  busy         out  1     state==ISSUE
//  done         out  1     one-cycle pulse on leaving ISSUE
//  issued_cnt   out  CNTW  handshakes since last start; saturates at all-ones
// BEHAVIOUR
//  Reset: state IDLE, fill=0, rd_ptr=0, lfsr=LFSR_SEED, abort_pend=0. Outputs: inst_valid=0, inst=0,
//   stallex=stallwb=0, busy=0, done=0, issued_cnt=0, ld_ready=1. rst mid-ISSUE drops inst_valid the
//   next cycle even if the offered inst was never accepted; the program is lost (fill=0).
//  Buffer: fill is $clog2(DEPTH)+1 bits. ld_ready = (state==IDLE) && fill<DEPTH.
//   ld_valid&&ld_ready writes buf[fill], fill++. ld_clear in IDLE sets fill=0 and wins over a same-cycle load.
//  FSM IDLE -> ISSUE: start in IDLE with fill_next>0. fill_next includes a load in the same cycle.
//   Clears issued_cnt, rd_ptr=0, abort_pend=0. start with fill_next==0 -> done pulses next cycle and
//   state stays IDLE. start outside IDLE is ignored.
//  ISSUE: inst_valid=1 and inst=buf[rd_ptr], both registered.
//   While inst_valid && !inst_ready, inst and inst_valid hold stable (no retraction, no change).
//   On handshake: issued_cnt++ (saturating).
//     If abort_pend||abort, or rd_ptr==fill-1 && !loop_en: inst_valid=0 next cycle, done pulses,
//     state -> IDLE.
//     Otherwise rd_ptr = (rd_ptr==fill-1) ? 0 : rd_ptr+1, and the next inst is valid next cycle.
//     This gives one inst per cycle at full throughput.
//   abort without a handshake sets abort_pend. The offered inst is still delivered before stopping.
//  Latency: start at cycle t -> inst_valid=1 with buf[0] at t+1.
//  Stall LFSR: 8-bit Fibonacci, taps 8,6,5,4; shifts every cycle in ISSUE, holds elsewhere.
//   stallex = busy && stall_en && lfsr[0]&lfsr[3].
//   stallwb = busy && stall_en && lfsr[1]&lfsr[5]&lfsr[6].
//   Both are registered outputs and are 0 in IDLE. loop_en, abort and stall_en are level inputs;
//   they are not registered beyond the rules above.
// TESTING
//  T1 load 8'h4B,8'h96 (SET r3? / ADD), start, inst_ready=1, stall_en=0 -> 2 handshakes back-to-back
//     starting t+1, done pulse, issued_cnt=2.
//  T2 hold inst_ready=0 for 5 cycles mid-program -> inst/inst_valid unchanged every cycle; resumes in order.
//  T3 loop_en=1, fill=3, 10 handshakes, then abort -> entry sequence 0,1,2,0,1,2,0,1,2,0;
//     stops after 10th/11th per abort timing, issued_cnt matches.
//  T4 load 8 entries -> ld_ready=0 on 9th; ld_clear -> fill=0; start -> done pulse, no inst_valid.
//  T5 rst asserted while inst_valid=1, inst_ready=0 -> next cycle inst_valid=0, busy=0, stall outs 0.
//  T6 connect pipeline, stall_en=1, loop 200 insts -> stallex/stallwb toggle; every inst issued once
//     per loop; scoreboard invariants hold throughout.

Source files
------------

// File: rtl/pipe_inst_issuer.sv
// Instruction-side driver for the ADD/SET/NAND pipeline.
// Holds a small host-loaded program and replays it once or in a loop over the
// inst/inst_valid/inst_ready handshake, with optional pseudo-random EX/WB stalls.
module pipe_inst_issuer #(
  parameter int          DEPTH     = 8,
  parameter int          CNTW      = 16,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      ld_inst,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic            ld_clear,
  input  logic            start,
  input  logic            loop_en,
  input  logic            abort,
  input  logic            stall_en,
  output logic [7:0]      inst,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic            stallex,
  output logic            stallwb,
  output logic            busy,
  output logic            done,
  output logic [CNTW-1:0] issued_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]      buf_q [DEPTH];
  logic [7:0]      lfsr_q, lfsr_d;
  logic            abort_pend_q, abort_pend_d;
  logic [7:0]      inst_q, inst_d;
  logic            inst_valid_q, inst_valid_d;
  logic            done_q, done_d;
  logic            stallex_q, stallex_d;
  logic            stallwb_q, stallwb_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            ld_fire, hs, last;

  assign ld_ready = (state_q == IDLE) && (fill_q < FW'(DEPTH));
  assign ld_fire  = ld_valid && ld_ready;
  assign hs       = inst_valid_q && inst_ready;
  assign last     = ({1'b0, rd_ptr_q} == (fill_q - FW'(1)));

  // Program buffer write port; only reachable in IDLE while not full.
  always_ff @(posedge clk) begin
    if (ld_fire) buf_q[fill_q[AW-1:0]] <= ld_inst;
  end

  // Next-state, buffer pointers, issue register and stall generation.
  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    rd_ptr_d     = rd_ptr_q;
    abort_pend_d = abort_pend_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    done_d       = 1'b0;
    cnt_d        = cnt_q;
    lfsr_d       = lfsr_q;
    case (state_q)
      IDLE: begin
        if (ld_clear)     fill_d = '0;
        else if (ld_fire) fill_d = fill_q + FW'(1);
        if (start) begin
          if (fill_d != '0) begin
            state_d      = ISSUE;
            cnt_d        = '0;
            rd_ptr_d     = '0;
            abort_pend_d = 1'b0;
            inst_valid_d = 1'b1;
            // An empty buffer that becomes non-empty this cycle means entry 0
            // is being written right now; forward it instead of reading stale data.
            inst_d       = (fill_q == '0) ? ld_inst : buf_q[0];
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        if (hs) begin
          if (cnt_q != '1) cnt_d = cnt_q + CNTW'(1);
          if (abort_pend_q || abort || (last && !loop_en)) begin
            state_d      = IDLE;
            inst_valid_d = 1'b0;
            done_d       = 1'b1;
          end else begin
            rd_ptr_d = last ? '0 : rd_ptr_q + AW'(1);
            inst_d   = buf_q[rd_ptr_d];
          end
        end else if (abort) begin
          abort_pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Stalls are computed from the next state so they are never high in IDLE.
    stallex_d = (state_d == ISSUE) && stall_en && lfsr_d[0] && lfsr_d[3];
    stallwb_d = (state_d == ISSUE) && stall_en && lfsr_d[1] && lfsr_d[5] && lfsr_d[6];
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fill_q       <= '0;
      rd_ptr_q     <= '0;
      abort_pend_q <= 1'b0;
      lfsr_q       <= LFSR_SEED;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      done_q       <= 1'b0;
      stallex_q    <= 1'b0;
      stallwb_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      rd_ptr_q     <= rd_ptr_d;
      abort_pend_q <= abort_pend_d;
      lfsr_q       <= lfsr_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      done_q       <= done_d;
      stallex_q    <= stallex_d;
      stallwb_q    <= stallwb_d;
      cnt_q        <= cnt_d;
    end
  end

  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign stallex    = stallex_q;
  assign stallwb    = stallwb_q;
  assign busy       = (state_q == ISSUE);
  assign done       = done_q;
  assign issued_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_inst_issuer.sv
// Directed bench for pipe_inst_issuer: reference model of the issuer's
// control state plus a queue of expected instructions in issue order.
module tb_pipe_inst_issuer;

  logic        clk = 1'b0;
  logic        rst, ld_valid, ld_ready, ld_clear, start, loop_en, abort, stall_en;
  logic        inst_valid, inst_ready, stallex, stallwb, busy, done;
  logic [7:0]  ld_inst, inst;
  logic [15:0] issued_cnt;

  pipe_inst_issuer #(.DEPTH(8), .CNTW(16), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .rst(rst), .ld_inst(ld_inst), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_clear(ld_clear), .start(start), .loop_en(loop_en), .abort(abort),
    .stall_en(stall_en), .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .stallex(stallex), .stallwb(stallwb), .busy(busy), .done(done), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model (reset values)
  logic       m_busy = 1'b0, m_pend = 1'b0, m_done = 1'b0, m_sen = 1'b0;
  logic [7:0] m_lfsr = 8'hA5;
  int         m_fill = 0, m_rd = 0, m_cnt = 0;
  logic [7:0] sb [$];
  int         tog_ex = 0, tog_wb = 0;
  logic       prev_ex = 1'b0, prev_wb = 1'b0;
  logic [7:0] prog [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at negedge, advance model at posedge, return #1 later.
  task automatic cyc();
    logic       hs;
    logic [7:0] dummy;
    int         fn;
    @(negedge clk);
    chk("busy", busy, m_busy);
    chk("inst_valid", inst_valid, m_busy);
    chk("ld_ready", ld_ready, !m_busy && (m_fill < 8));
    chk("done", done, m_done);
    chk("issued_cnt", issued_cnt, m_cnt);
    chk("stallex", stallex, m_busy && m_sen && m_lfsr[0] && m_lfsr[3]);
    chk("stallwb", stallwb, m_busy && m_sen && m_lfsr[1] && m_lfsr[5] && m_lfsr[6]);
    if (m_busy) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) chk("inst", inst, sb[0]);
    end
    if (stallex !== prev_ex) tog_ex++;
    if (stallwb !== prev_wb) tog_wb++;
    prev_ex = stallex;
    prev_wb = stallwb;
    hs = m_busy && inst_ready;
    @(posedge clk);
    m_done = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_fill = 0; m_rd = 0; m_pend = 1'b0; m_cnt = 0; m_lfsr = 8'hA5;
      sb.delete();
    end else if (!m_busy) begin
      fn = m_fill;
      if (ld_clear) fn = 0;
      else if (ld_valid && m_fill < 8) fn = m_fill + 1;
      m_fill = fn;
      if (start) begin
        if (fn > 0) begin m_busy = 1'b1; m_cnt = 0; m_rd = 0; m_pend = 1'b0; end
        else m_done = 1'b1;
      end
    end else begin
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
      if (hs) begin
        if (sb.size() != 0) dummy = sb.pop_front();
        if (m_cnt < 65535) m_cnt++;
        if (m_pend || abort || (m_rd == m_fill - 1 && !loop_en)) begin
          m_busy = 1'b0; m_done = 1'b1;
        end else begin
          m_rd = (m_rd == m_fill - 1) ? 0 : m_rd + 1;
        end
      end else if (abort) begin
        m_pend = 1'b1;
      end
    end
    m_sen = stall_en;
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    ld_inst = v; ld_valid = 1'b1; cyc(); ld_valid = 1'b0;
  endtask

  task automatic clear();
    ld_clear = 1'b1; cyc(); ld_clear = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (m_busy && n < budget) begin cyc(); n++; end
    chk(tag, m_busy, 0);
    cyc();
  endtask

  initial begin
    int n;
    rst = 1'b1; ld_inst = '0; ld_valid = 0; ld_clear = 0; start = 0; loop_en = 0;
    abort = 0; stall_en = 0; inst_ready = 0;
    @(posedge clk); #1;
    cyc();
    rst = 1'b0;
    cyc();
    chk("rst_inst", inst, 8'h00);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_cnt", issued_cnt, 0);

    // T1: two-entry program, single pass, full throughput
    load(8'h4B); load(8'h96);
    sb.push_back(8'h4B); sb.push_back(8'h96);
    kick();
    chk("t1_lat_valid", inst_valid, 1);
    chk("t1_lat_inst", inst, 8'h4B);
    inst_ready = 1'b1;
    wait_idle("t1_timeout", 20);
    chk("t1_cnt", issued_cnt, 2);
    chk("t1_sb_drained", sb.size(), 0);
    inst_ready = 1'b0;

    // T2: backpressure for 5 cycles mid-program
    clear();
    load(8'h11); load(8'h62); load(8'hC7); load(8'h3D);
    sb.push_back(8'h11); sb.push_back(8'h62); sb.push_back(8'hC7); sb.push_back(8'h3D);
    kick();
    inst_ready = 1'b1; cyc();
    inst_ready = 1'b0; repeat (5) cyc();
    inst_ready = 1'b1;
    wait_idle("t2_timeout", 20);
    chk("t2_cnt", issued_cnt, 4);
    chk("t2_sb_drained", sb.size(), 0);
    inst_ready = 1'b0;

    // T3: looping three entries, abort coincident with the 10th handshake
    clear();
    load(8'hA1); load(8'hB2); load(8'hC3);
    for (int i = 0; i < 10; i++) sb.push_back((i % 3 == 0) ? 8'hA1 : (i % 3 == 1) ? 8'hB2 : 8'hC3);
    loop_en = 1'b1;
    kick();
    inst_ready = 1'b1;
    n = 0;
    while (m_cnt < 9 && n < 50) begin cyc(); n++; end
    abort = 1'b1; cyc(); abort = 1'b0;
    wait_idle("t3_timeout", 20);
    chk("t3_cnt", issued_cnt, 10);
    chk("t3_sb_drained", sb.size(), 0);

    // T3b: abort while stalled is remembered; offered inst still delivered
    sb.push_back(8'hA1); sb.push_back(8'hB2); sb.push_back(8'hC3);
    kick();
    cyc(); cyc();
    inst_ready = 1'b0; abort = 1'b1; cyc();
    abort = 1'b0; cyc(); cyc();
    inst_ready = 1'b1;
    wait_idle("t3b_timeout", 20);
    chk("t3b_cnt", issued_cnt, 3);
    chk("t3b_sb_drained", sb.size(), 0);
    loop_en = 1'b0; inst_ready = 1'b0;

    // T4: full buffer, clear, empty start, load+start forwarding, clear wins
    clear();
    for (int i = 0; i < 8; i++) load(8'(8'h20 + i));
    chk("t4_full", ld_ready, 0);
    ld_inst = 8'hFF; ld_valid = 1'b1; cyc(); ld_valid = 1'b0;
    clear();
    kick();
    chk("t4_done", done, 1);
    chk("t4_novalid", inst_valid, 0);
    cyc();
    ld_inst = 8'h5A; ld_valid = 1'b1; start = 1'b1; sb.push_back(8'h5A);
    cyc();
    ld_valid = 1'b0; start = 1'b0;
    chk("t4_fwd_inst", inst, 8'h5A);
    inst_ready = 1'b1;
    wait_idle("t4_timeout", 10);
    inst_ready = 1'b0;
    ld_clear = 1'b1; ld_valid = 1'b1; ld_inst = 8'h77; start = 1'b1;
    cyc();
    ld_clear = 1'b0; ld_valid = 1'b0; start = 1'b0;
    chk("t4_clrwin_busy", busy, 0);
    chk("t4_clrwin_done", done, 1);
    cyc();

    // T5: reset while an instruction is stalled
    stall_en = 1'b1;
    load(8'h01); load(8'h02); load(8'h03);
    sb.push_back(8'h01); sb.push_back(8'h02); sb.push_back(8'h03);
    kick();
    repeat (3) cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("t5_valid", inst_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_stallex", stallex, 0);
    chk("t5_stallwb", stallwb, 0);
    chk("t5_ld_ready", ld_ready, 1);
    kick();
    chk("t5_lost_done", done, 1);

    // T6: 200 looped instructions with random backpressure and stalls
    for (int i = 0; i < 8; i++) begin prog[i] = 8'($urandom); load(prog[i]); end
    for (int i = 0; i < 200; i++) sb.push_back(prog[i % 8]);
    loop_en = 1'b1;
    kick();
    n = 0;
    while (m_busy && n < 3000) begin
      inst_ready = ($urandom_range(0, 9) < 7);
      abort = (m_cnt >= 199);
      cyc();
      n++;
    end
    abort = 1'b0; inst_ready = 1'b0; loop_en = 1'b0;
    wait_idle("t6_timeout", 5);
    chk("t6_cnt", issued_cnt, 200);
    chk("t6_sb_drained", sb.size(), 0);
    chk("t6_stall_toggle", (tog_ex > 0) && (tog_wb > 0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
